// File: rtl/decoder_pkg.sv
// Shared encodings, decoded-bundle and write-entry types for the decode stage.
package decoder_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_JR  = 6'h08;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_XOR = 3'd2,
        ALU_SLT = 3'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_REG    = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        DIN_ALU = 2'd0,
        DIN_MEM = 2'd1,
        DIN_PC4 = 2'd2
    } reg_din_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] addr;
        logic       is_load;
    } wr_entry_t;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  reg_w_addr;
        logic [25:0] j_addr;
        logic [31:0] imm;
        alu_op_e     op;
        pc_src_e     pc_src;
        reg_din_e    reg_din;
        logic        reg_we;
        logic        dm_we;
        logic        alu_b_src;
        logic        illegal;
    } dec_t;

    // True when either enabled read register matches a live pending write.
    function automatic logic entry_hit(input wr_entry_t e,
                                       input logic [4:0] ra, input logic ra_en,
                                       input logic [4:0] rb, input logic rb_en);
        return e.valid && ((ra_en && (e.addr == ra)) || (rb_en && (e.addr == rb)));
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational instruction decode: control bundle, read set and write entry.
module decode_comb
    import decoder_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec,
    output logic        rs_rd,
    output logic        rt_rd,
    output wr_entry_t   wr
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    always_comb begin
        dec            = '0;
        dec.rs         = instr[25:21];
        dec.rt         = instr[20:16];
        dec.rd         = instr[15:11];
        dec.j_addr     = instr[25:0];
        dec.imm        = {{16{instr[15]}}, instr[15:0]};
        dec.reg_w_addr = (opcode == OPC_RTYPE) ? instr[15:11] : instr[20:16];
        dec.op         = ALU_ADD;
        dec.pc_src     = PC_PLUS4;
        dec.reg_din    = DIN_ALU;

        case (opcode)
            OPC_RTYPE: begin
                case (funct)
                    FN_ADD: dec.reg_we = 1'b1;
                    FN_SUB: begin
                        dec.reg_we = 1'b1;
                        dec.op     = ALU_SUB;
                    end
                    FN_SLT: begin
                        dec.reg_we = 1'b1;
                        dec.op     = ALU_SLT;
                    end
                    FN_JR:   dec.pc_src  = PC_REG;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OPC_LW: begin
                dec.reg_we    = 1'b1;
                dec.reg_din   = DIN_MEM;
                dec.alu_b_src = 1'b1;
            end
            OPC_SW: begin
                dec.dm_we     = 1'b1;
                dec.alu_b_src = 1'b1;
            end
            OPC_J: dec.pc_src = PC_JUMP;
            OPC_JAL: begin
                dec.pc_src     = PC_JUMP;
                dec.reg_we     = 1'b1;
                dec.reg_din    = DIN_PC4;
                dec.reg_w_addr = REG_RA;
            end
            OPC_BNE: begin
                dec.pc_src = PC_BRANCH;
                dec.op     = ALU_SUB;
            end
            OPC_XORI: begin
                dec.imm       = {16'h0000, instr[15:0]};
                dec.op        = ALU_XOR;
                dec.reg_we    = 1'b1;
                dec.alu_b_src = 1'b1;
            end
            OPC_ADDI: begin
                dec.reg_we    = 1'b1;
                dec.alu_b_src = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase

        // $0 is hardwired, so it never creates or consumes a dependency.
        rs_rd = (opcode != OPC_J) && (opcode != OPC_JAL) && (dec.rs != '0);
        rt_rd = ((opcode == OPC_RTYPE) || (opcode == OPC_BNE) || (opcode == OPC_SW))
                && (dec.rt != '0);

        wr.valid   = dec.reg_we && (dec.reg_w_addr != '0);
        wr.addr    = dec.reg_w_addr;
        wr.is_load = (opcode == OPC_LW);
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready handshake and a RAW-hazard write scoreboard.
module decode_stage
    import decoder_pkg::*;
#(
    parameter int unsigned PIPE_DEPTH = 2,
    parameter bit          FORWARD    = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] instr,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  regWAddr,
    output logic [25:0] jAddr,
    output logic [31:0] imm,
    output logic [2:0]  op,
    output logic [1:0]  pcSrcCtrl,
    output logic [1:0]  regDInCtrl,
    output logic        regWe,
    output logic        dmWe,
    output logic        aluBSrcCtrl,
    output logic        illegal
);

    dec_t      dec;
    logic      rs_rd;
    logic      rt_rd;
    wr_entry_t dec_wr;

    dec_t      out_d, out_q;
    wr_entry_t out_wr_d, out_wr_q;
    logic      out_valid_d, out_valid_q;
    wr_entry_t sb_d [PIPE_DEPTH];
    wr_entry_t sb_q [PIPE_DEPTH];
    logic      hazard;
    logic      accept;

    decode_comb u_decode_comb (
        .instr (instr),
        .dec   (dec),
        .rs_rd (rs_rd),
        .rt_rd (rt_rd),
        .wr    (dec_wr)
    );

    always_comb begin
        hazard = 1'b0;
        if (out_valid_q && entry_hit(out_wr_q, dec.rs, rs_rd, dec.rt, rt_rd))
            hazard = FORWARD ? out_wr_q.is_load : 1'b1;
        if (!FORWARD) begin
            for (int unsigned i = 0; i < PIPE_DEPTH; i++)
                if (entry_hit(sb_q[i], dec.rs, rs_rd, dec.rt, rt_rd))
                    hazard = 1'b1;
        end
    end

    assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        out_wr_d    = out_wr_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_d       = dec;
            out_wr_d    = dec_wr;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // A flushed instruction leaves an empty slot so older writes keep their age.
        sb_d = sb_q;
        if (out_ready) begin
            sb_d[0] = (out_valid_q && !flush) ? out_wr_q : '0;
            for (int unsigned i = 1; i < PIPE_DEPTH; i++)
                sb_d[i] = sb_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_wr_q    <= '0;
            for (int unsigned i = 0; i < PIPE_DEPTH; i++)
                sb_q[i] <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            out_wr_q    <= out_wr_d;
            sb_q        <= sb_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign rs          = out_q.rs;
    assign rt          = out_q.rt;
    assign rd          = out_q.rd;
    assign regWAddr    = out_q.reg_w_addr;
    assign jAddr       = out_q.j_addr;
    assign imm         = out_q.imm;
    assign op          = out_q.op;
    assign pcSrcCtrl   = out_q.pc_src;
    assign regDInCtrl  = out_q.reg_din;
    assign regWe       = out_q.reg_we;
    assign dmWe        = out_q.dm_we;
    assign aluBSrcCtrl = out_q.alu_b_src;
    assign illegal     = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Three decode_stage configurations share one stimulus stream; each is checked every cycle
// against an instruction-level reference model.
module tb_decode_stage;

    localparam int NI = 3;
    localparam int unsigned DP [NI] = '{2, 2, 1};
    localparam bit          FW [NI] = '{1'b0, 1'b1, 1'b0};

    localparam logic [31:0] I_ADD3    = 32'h00221820;
    localparam logic [31:0] I_XORI    = 32'h38248000;
    localparam logic [31:0] I_ADDI_N  = 32'h20258000;
    localparam logic [31:0] I_JAL     = 32'h0C000010;
    localparam logic [31:0] I_ILL     = 32'hFC000000;
    localparam logic [31:0] I_LW5     = 32'h8C250000;
    localparam logic [31:0] I_DEP5    = 32'h00A23020;
    localparam logic [31:0] I_INDEP   = 32'h00E23020;
    localparam logic [31:0] I_ADDI5   = 32'h20250001;
    localparam logic [31:0] I_ADDI0   = 32'h20200001;
    localparam logic [31:0] I_RD0     = 32'h00023020;
    localparam logic [31:0] I_ADD7    = 32'h00223820;

    typedef struct packed {
        logic [4:0]  rs, rt, rd, wa;
        logic [25:0] ja;
        logic [31:0] imm;
        logic [2:0]  op;
        logic [1:0]  pcs, rdin;
        logic        rwe, dwe, alub, ill;
    } bund_t;

    typedef struct {
        logic [4:0]  addr;
        bit          ld;
        int unsigned stamp;
    } pend_t;

    logic        clk, reset, flush, in_valid, out_ready;
    logic [31:0] instr;
    logic        in_ready_o [NI];
    logic        out_valid_o [NI];
    logic [4:0]  rs_o [NI], rt_o [NI], rd_o [NI], wa_o [NI];
    logic [25:0] ja_o [NI];
    logic [31:0] imm_o [NI];
    logic [2:0]  op_o [NI];
    logic [1:0]  pcs_o [NI], rdin_o [NI];
    logic        rwe_o [NI], dwe_o [NI], alub_o [NI], ill_o [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        decode_stage #(.PIPE_DEPTH(DP[g]), .FORWARD(FW[g])) u_dut (
            .clk         (clk),
            .reset       (reset),
            .flush       (flush),
            .instr       (instr),
            .in_valid    (in_valid),
            .in_ready    (in_ready_o[g]),
            .out_valid   (out_valid_o[g]),
            .out_ready   (out_ready),
            .rs          (rs_o[g]),
            .rt          (rt_o[g]),
            .rd          (rd_o[g]),
            .regWAddr    (wa_o[g]),
            .jAddr       (ja_o[g]),
            .imm         (imm_o[g]),
            .op          (op_o[g]),
            .pcSrcCtrl   (pcs_o[g]),
            .regDInCtrl  (rdin_o[g]),
            .regWe       (rwe_o[g]),
            .dmWe        (dwe_o[g]),
            .aluBSrcCtrl (alub_o[g]),
            .illegal     (ill_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    bit    chk_en = 1'b0;
    bund_t mo [NI];
    logic [31:0] mi [NI];
    bit    mv [NI];
    pend_t pend [NI][$];
    int unsigned rc [NI];

    task automatic chk(input string nm, input int k, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s u%0d: got %h want %h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Reference decode straight from the instruction-set table.
    function automatic bund_t ref_dec(input logic [31:0] w);
        bund_t b;
        logic [5:0] opc, fn;
        opc = w[31:26];
        fn  = w[5:0];
        b = '0;
        b.rs = w[25:21]; b.rt = w[20:16]; b.rd = w[15:11]; b.ja = w[25:0];
        b.imm = {{16{w[15]}}, w[15:0]};
        b.wa = (opc == 6'h00) ? w[15:11] : w[20:16];
        case (opc)
            6'h00: case (fn)
                6'h20: b.rwe = 1;
                6'h22: begin b.rwe = 1; b.op = 3'd1; end
                6'h2A: begin b.rwe = 1; b.op = 3'd3; end
                6'h08: b.pcs = 2'd3;
                default: b.ill = 1;
            endcase
            6'h23: begin b.rwe = 1; b.rdin = 2'd1; b.alub = 1; end
            6'h2B: begin b.dwe = 1; b.alub = 1; end
            6'h02: b.pcs = 2'd2;
            6'h03: begin b.pcs = 2'd2; b.rwe = 1; b.rdin = 2'd2; b.wa = 5'd31; end
            6'h05: begin b.pcs = 2'd1; b.op = 3'd1; end
            6'h0E: begin b.imm = {16'h0, w[15:0]}; b.op = 3'd2; b.rwe = 1; b.alub = 1; end
            6'h08: begin b.rwe = 1; b.alub = 1; end
            default: b.ill = 1;
        endcase
        return b;
    endfunction

    function automatic bit reads(input logic [31:0] w, input logic [4:0] r);
        logic [5:0] opc;
        bit use_rs, use_rt;
        opc = w[31:26];
        if (r == 5'd0) return 1'b0;
        use_rs = (opc != 6'h02) && (opc != 6'h03);
        use_rt = (opc == 6'h00) || (opc == 6'h05) || (opc == 6'h2B);
        return (use_rs && w[25:21] == r) || (use_rt && w[20:16] == r);
    endfunction

    function automatic bit m_hazard(input int k, input logic [31:0] w);
        bit h;
        h = 1'b0;
        if (mv[k] && mo[k].rwe && reads(w, mo[k].wa) && (!FW[k] || mi[k][31:26] == 6'h23))
            h = 1'b1;
        if (!FW[k])
            for (int j = 0; j < pend[k].size(); j++)
                if (reads(w, pend[k][j].addr)) h = 1'b1;
        return h;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            bit    rdy, acc;
            bund_t act;
            pend_t e;
            rdy = (!mv[k] || out_ready) && !m_hazard(k, instr) && !flush;
            if (chk_en) begin
                act = {rs_o[k], rt_o[k], rd_o[k], wa_o[k], ja_o[k], imm_o[k], op_o[k],
                       pcs_o[k], rdin_o[k], rwe_o[k], dwe_o[k], alub_o[k], ill_o[k]};
                chk("out_valid", k, 96'(out_valid_o[k]), 96'(mv[k]));
                chk("bundle", k, 96'(act), 96'(mo[k]));
                chk("in_ready", k, 96'(in_ready_o[k]), 96'(rdy));
            end
            acc = in_valid && rdy;
            if (reset) begin
                mv[k] = 0; mo[k] = '0; mi[k] = '0; rc[k] = 0;
                pend[k].delete();
            end else begin
                // A write stays visible for PIPE_DEPTH downstream advances after leaving the stage.
                if (out_ready) begin
                    rc[k]++;
                    while (pend[k].size() > 0 && rc[k] - pend[k][0].stamp >= DP[k])
                        void'(pend[k].pop_front());
                    if (mv[k] && !flush && mo[k].rwe && mo[k].wa != 5'd0) begin
                        e.addr = mo[k].wa; e.ld = (mi[k][31:26] == 6'h23); e.stamp = rc[k];
                        pend[k].push_back(e);
                    end
                end
                if (flush) mv[k] = 0;
                else if (acc) begin mv[k] = 1; mo[k] = ref_dec(instr); mi[k] = instr; end
                else if (out_ready) mv[k] = 0;
            end
        end
    end

    task automatic put(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
        in_valid = v; instr = w; out_ready = ordy; flush = fl;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        put(0, 32'h0, 1, 0);
        repeat (5) tick();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  a, b, c;
        logic [15:0] im;
        a  = 5'($urandom_range(0, 7));
        b  = 5'($urandom_range(0, 7));
        c  = 5'($urandom_range(0, 7));
        im = 16'($urandom);
        case ($urandom_range(0, 12))
            0:  return {6'h00, a, b, c, 5'd0, 6'h20};
            1:  return {6'h00, a, b, c, 5'd0, 6'h22};
            2:  return {6'h00, a, b, c, 5'd0, 6'h2A};
            3:  return {6'h00, a, 15'd0, 6'h08};
            4:  return {6'h23, a, b, im};
            5:  return {6'h2B, a, b, im};
            6:  return {6'h02, 26'($urandom)};
            7:  return {6'h03, 26'($urandom)};
            8:  return {6'h05, a, b, im};
            9:  return {6'h0E, a, b, im};
            10: return {6'h08, a, b, im};
            11: return {6'h3F, a, b, im};
            default: return {6'h00, a, b, c, 5'd0, 6'h3C};
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int s0, s1, s2;
        for (int k = 0; k < NI; k++) begin
            mv[k] = 0; mo[k] = '0; mi[k] = '0; rc[k] = 0;
        end
        reset = 1; flush = 0; in_valid = 1; instr = I_ADD3; out_ready = 1;
        @(posedge clk);
        chk_en = 1'b1;
        #1;
        tick();
        for (int k = 0; k < NI; k++) begin
            chk("rst_out_valid", k, 96'(out_valid_o[k]), 96'd0);
            chk("rst_imm", k, 96'(imm_o[k]), 96'd0);
            chk("rst_wa", k, 96'(wa_o[k]), 96'd0);
        end
        reset = 0;
        put(0, 32'h0, 1, 0);
        for (int k = 0; k < NI; k++) chk("rst_in_ready", k, 96'(in_ready_o[k]), 96'd1);

        put(1, I_ADD3, 1, 0); tick();
        chk("add_valid", 0, 96'(out_valid_o[0]), 96'd1);
        chk("add_op", 0, 96'(op_o[0]), 96'd0);
        chk("add_wa", 0, 96'(wa_o[0]), 96'd3);
        chk("add_we", 0, 96'(rwe_o[0]), 96'd1);
        put(1, I_XORI, 1, 0); tick();
        chk("xori_imm", 0, 96'(imm_o[0]), 96'h00008000);
        put(1, I_ADDI_N, 1, 0); tick();
        chk("addi_imm", 0, 96'(imm_o[0]), 96'hFFFF8000);
        put(1, I_JAL, 1, 0); tick();
        chk("jal_wa", 0, 96'(wa_o[0]), 96'd31);
        chk("jal_din", 0, 96'(rdin_o[0]), 96'd2);
        put(1, I_ILL, 1, 0); tick();
        chk("ill_flag", 0, 96'(ill_o[0]), 96'd1);
        chk("ill_we", 0, 96'(rwe_o[0]), 96'd0);
        drain();

        put(1, I_LW5, 1, 0); tick();
        put(1, I_DEP5, 1, 0);
        chk("lu_stall", 1, 96'(in_ready_o[1]), 96'd0);
        tick();
        chk("lu_bubble", 1, 96'(out_valid_o[1]), 96'd0);
        chk("lu_release", 1, 96'(in_ready_o[1]), 96'd1);
        tick();
        chk("lu_issue", 1, 96'(out_valid_o[1]), 96'd1);
        chk("lu_wa", 1, 96'(wa_o[1]), 96'd6);
        drain();
        put(1, I_LW5, 1, 0); tick();
        put(1, I_INDEP, 1, 0);
        chk("nolu_ready", 1, 96'(in_ready_o[1]), 96'd1);
        tick();
        chk("nolu_valid", 1, 96'(out_valid_o[1]), 96'd1);
        drain();

        put(1, I_ADDI5, 1, 0); tick();
        put(1, I_DEP5, 1, 0);
        s0 = 0; s1 = 0; s2 = 0;
        for (int c = 0; c < 10 && !in_ready_o[0]; c++) begin
            s0++;
            if (!in_ready_o[1]) s1++;
            if (!in_ready_o[2]) s2++;
            tick();
        end
        chk("raw_stall_d2", 0, 96'(s0), 96'd3);
        chk("raw_stall_fwd", 1, 96'(s1), 96'd0);
        chk("raw_stall_d1", 2, 96'(s2), 96'd2);
        tick();
        drain();
        put(1, I_ADDI0, 1, 0); tick();
        put(1, I_RD0, 1, 0);
        s0 = 0;
        for (int c = 0; c < 10 && !in_ready_o[0]; c++) begin s0++; tick(); end
        chk("r0_stall", 0, 96'(s0), 96'd0);
        tick();
        drain();

        put(1, I_ADDI5, 1, 0); tick();
        put(1, I_XORI, 0, 0);
        for (int c = 0; c < 4; c++) begin
            chk("bp_ready", 0, 96'(in_ready_o[0]), 96'd0);
            chk("bp_valid", 0, 96'(out_valid_o[0]), 96'd1);
            chk("bp_imm", 0, 96'(imm_o[0]), 96'd1);
            chk("bp_wa", 0, 96'(wa_o[0]), 96'd5);
            tick();
        end
        put(1, I_XORI, 1, 0);
        chk("bp_rel_ready", 0, 96'(in_ready_o[0]), 96'd1);
        tick();
        chk("bp_next_wa", 0, 96'(wa_o[0]), 96'd4);
        chk("bp_next_imm", 0, 96'(imm_o[0]), 96'h8000);
        put(0, 32'h0, 1, 0); tick();
        chk("bp_no_dup", 0, 96'(out_valid_o[0]), 96'd0);
        drain();

        put(1, I_ADDI5, 1, 0); tick();
        put(1, I_ADD7, 1, 0); tick();
        put(1, I_DEP5, 1, 1);
        chk("fl_ready", 0, 96'(in_ready_o[0]), 96'd0);
        tick();
        chk("fl_killed", 0, 96'(out_valid_o[0]), 96'd0);
        put(1, I_DEP5, 1, 0);
        chk("fl_old_stall", 0, 96'(in_ready_o[0]), 96'd0);
        tick();
        chk("fl_release", 0, 96'(in_ready_o[0]), 96'd1);
        tick();
        chk("fl_issue_wa", 0, 96'(wa_o[0]), 96'd6);
        drain();

        put(1, I_ADDI5, 1, 0); tick();
        put(1, I_DEP5, 1, 0);
        chk("rs_stall", 0, 96'(in_ready_o[0]), 96'd0);
        reset = 1;
        tick();
        reset = 0;
        #1;
        chk("rs_release", 0, 96'(in_ready_o[0]), 96'd1);
        tick();
        drain();

        repeat (3000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            instr     = rand_instr();
            out_ready = ($urandom_range(0, 4) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 0;
        put(0, 32'h0, 1, 0);
        tick();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, hazard-aware instruction decode stage for the pipelined MIPS-subset core. It sits between fetch and execute, decodes one 32-bit instruction per cycle into the existing control bundle, and holds one output register with a valid/ready handshake. It also contains a parametrised write scoreboard that detects RAW hazards and inserts bubbles. An optional forwarding-aware mode relaxes stalls to load-use only.

## Interface
- `PIPE_DEPTH`, default 2: number of downstream stages tracked for pending register writes, with a minimum of 1.
- `FORWARD`, default 0: selects the stall policy. 0 stalls on any pending write match. 1 stalls only on load-use.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  kills the output register contents and blocks acceptance this cycle.
- `instr`  in  32  instruction word.
- `in_valid` / `in_ready`  in / out  1  upstream handshake.
- `out_valid` / `out_ready`  out / in  1  downstream handshake.
- `rs`, `rt`, `rd`, `regWAddr`  out  5 each  register fields and write address.
- `jAddr`  out  26  jump target field.
- `imm`  out  32  extended immediate.
- `op`  out  3  ALU op.
- `pcSrcCtrl`, `regDInCtrl`  out  2 each  PC source select and register write-data select.
- `regWe`, `dmWe`, `aluBSrcCtrl`, `illegal`  out  1 each  control bits.

## Operation
- Supported opcodes: LW 0x23, SW 0x2B, J 0x02, JAL 0x03, BNE 0x05, XORI 0x0E, ADDI 0x08.
- Supported R-type (opcode 0x00) functs: ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08.
- ALU `op` encoding: ADD=0, SUB=1, XOR=2, SLT=3.
- `pcSrcCtrl` encoding: PC+4=0, branch=1, jump=2, register=3.
- `regDInCtrl` encoding: ALU=0, memory=1, PC+4=2.
- `imm` is sign-extended from [15:0]. XORI is the exception and is zero-extended.
- `regWAddr` is rd for R-type, rt for I-type, and 31 for JAL.
- `aluBSrcCtrl` is 1 for immediate operands (LW, SW, ADDI, XORI).
- Any other encoding is illegal. It decodes with `illegal`=1, `regWe`=0, `dmWe`=0, `pcSrcCtrl`=0.
- Read set of an instruction: rs for all except J/JAL; rt additionally for R-type, BNE and SW. Register 0 never participates in hazards.
- Write entry of an instruction: {valid=`regWe`, addr=`regWAddr`, isLoad=(opcode==LW)}. An entry with addr 0 is treated as invalid.
- The scoreboard is a PIPE_DEPTH shift register of write entries. It shifts on every cycle with `out_ready`=1:
  - entry 0 receives the output register's entry if `out_valid`, else empty;
  - the entry in the last position drops out.
- Hazard with FORWARD=0: any read register matches the output register entry or any scoreboard entry.
- Hazard with FORWARD=1: a read register matches the output register entry and that entry is a load.
- `in_ready` = (!`out_valid` | `out_ready`) & !hazard & !`flush`.
- On an accept (`in_valid` & `in_ready`), the output register loads the decoded bundle and sets `out_valid`=1.
- If `out_ready` is high but nothing is accepted, `out_valid` becomes 0 (a bubble).
- If `out_valid` & !`out_ready`, the output register holds every field stable.
- On `flush`, `out_valid` becomes 0 next cycle. The scoreboard still shifts normally, with the killed entry replaced by empty. Older in-flight writes remain tracked.

## Timing
- Decode latency is one cycle from accept to `out_valid`.
- Throughput is one instruction per cycle when there is no hazard.
- Reset: `out_valid`=0, all decoded outputs 0, scoreboard empty. `in_ready` is 1 in the first cycle after reset.
- Stall length with FORWARD=0: a dependent instruction directly behind its producer waits PIPE_DEPTH+1 cycles, assuming `out_ready`=1.
- Stall length with FORWARD=1: load-use costs exactly one bubble.
- Simultaneous `flush` and `in_valid`: `flush` wins. Nothing is accepted and `in_ready`=0.
- Simultaneous `reset` and `flush`: `reset` wins.
- Reset mid-stall: the scoreboard is cleared, so the stall is released on the following cycle.
- All outputs are registered, except `in_ready`, which is combinational from the state, `instr`, `out_ready` and `flush`.

## Structure
- `decoder_pkg` holds the opcode and funct constants, the ALU op encoding, the `pcSrcCtrl`/`regDInCtrl` encodings, and the write-entry struct.
- Sub-module `decode_comb` is the purely combinational field and control decode; it also produces the read set and write entry. `decode_stage` instantiates it and adds the output register, scoreboard and handshake.

## Test plan
- Reset: assert `reset` for 2 cycles with `in_valid`=1 -> `out_valid`=0, all outputs 0; first post-reset cycle has `in_ready`=1.
- Decode sweep: ADD $3,$1,$2 (0x00221820) -> next cycle `op`=0, `regWAddr`=3, `regWe`=1. XORI $4,$1,0x8000 -> `imm`=0x00008000. ADDI imm 0x8000 -> `imm`=0xFFFF8000. JAL -> `regWAddr`=31, `regDInCtrl`=2. Opcode 0x3F -> `illegal`=1, `regWe`=0.
- FORWARD=1 load-use: LW $5,0($1) then ADD $6,$5,$2 -> exactly one bubble (`out_valid`=0 for one cycle). ADD $6,$7,$2 after the LW -> no bubble.
- FORWARD=0, PIPE_DEPTH=2: ADDI $5 then ADD reading $5 -> 3 stall cycles. An instruction writing $0 followed by a reader of $0 -> 0 stall cycles.
- Backpressure: hold `out_ready`=0 for 4 cycles while `out_valid`=1 -> outputs stable and `in_ready`=0. Release -> the next instruction issues the following cycle with no loss or duplication.
- Flush: pulse `flush` with `in_valid`=1 and `out_valid`=1 -> next cycle `out_valid`=0, the instruction is not accepted, and older scoreboard entries still stall a dependent reader.
